// File: rtl/controlPkg.sv
`default_nettype none
// ============================================================================
//  Module      : controlPkg
//  Description : Shared types and constants for the pipeline control logic.
//                Holds the scoreboard entry record used by the hazard
//                scoreboard and the architectural zero-register index (XZR).
//  Revision    : 1.0 - initial release
// ============================================================================
package controlPkg;

    // Architectural zero register: reads as zero, writes are discarded, so it
    // never creates a dependency.
    localparam int c_XZR = 31;

    // Destination field width inside a scoreboard entry. Register addresses
    // are stored zero-extended to this width so the entry type does not depend
    // on the ADDR_W parameter of the instantiating module (ADDR_W <= 16).
    localparam int c_RD_MAX_W = 16;

    typedef struct packed {
        logic                  valid;
        logic [c_RD_MAX_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } sb_entry_t;

endpackage : controlPkg
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_match
//  Description : Finds the youngest in-flight producer of one source operand.
//                Entry index 0 of i_entries is pipeline entry 1 (EX).
//  Ports       : i_src           - source register address
//                i_src_used      - operand is actually read
//                i_entries       - scoreboard entries, youngest first
//                o_match_idx     - 0 = no producer, k = youngest match at k
//                o_match_is_load - the youngest matching producer is a load
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import controlPkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = c_XZR,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0]     i_src,
    input  logic                  i_src_used,
    input  sb_entry_t [DEPTH-1:0] i_entries,
    output logic [SEL_W-1:0]      o_match_idx,
    output logic                  o_match_is_load
);

    logic w_src_live;

    always_comb begin
        w_src_live      = i_src_used && (i_src != ADDR_W'(ZERO_REG));
        o_match_idx     = '0;
        o_match_is_load = 1'b0;
        // Walk oldest to youngest so the youngest hit is the last assignment.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_src_live && i_entries[k].valid && i_entries[k].reg_write &&
                (i_entries[k].rd == c_RD_MAX_W'(i_src))) begin
                o_match_idx     = SEL_W'(k + 1);
                o_match_is_load = i_entries[k].is_load;
            end
        end
    end

endmodule : hazard_match
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Data-hazard scoreboard for an in-order pipeline. Tracks the
//                destinations of the DEPTH instructions after RF, selects the
//                forwarding source per operand and raises a load-use stall.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                rf_valid           - RF stage holds a real instruction
//                rf_rn / rf_rm      - source A / B addresses (+ *_used)
//                rf_rd, rf_reg_write, rf_is_load - RF destination info
//                flush              - kill the RF instruction
//                stall              - hold IF/RF, bubble into EX
//                fwd_sel_a/b        - 0 = register file, k = entry k
//                stall_cnt          - saturating stall-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import controlPkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = c_XZR,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rf_valid,
    input  logic [ADDR_W-1:0]              rf_rn,
    input  logic [ADDR_W-1:0]              rf_rm,
    input  logic                           rf_rn_used,
    input  logic                           rf_rm_used,
    input  logic [ADDR_W-1:0]              rf_rd,
    input  logic                           rf_reg_write,
    input  logic                           rf_is_load,
    input  logic                           flush,
    output logic                           stall,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_sel_a,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_sel_b,
    output logic [CNT_W-1:0]               stall_cnt
);

    localparam int c_SEL_W = $clog2(DEPTH + 1);
    // A latency beyond the tracked depth behaves like "every tracked entry".
    localparam int c_LAT_CLAMP = (LOAD_LAT > DEPTH) ? DEPTH : LOAD_LAT;
    localparam logic [c_SEL_W-1:0] c_LOAD_LAT = c_SEL_W'(c_LAT_CLAMP);

    sb_entry_t [DEPTH-1:0] r_sb_q;
    sb_entry_t [DEPTH-1:0] w_sb_d;
    logic [CNT_W-1:0]      r_stall_cnt_q;
    logic [CNT_W-1:0]      w_stall_cnt_d;

    logic [c_SEL_W-1:0] w_a_idx;
    logic [c_SEL_W-1:0] w_b_idx;
    logic               w_a_load;
    logic               w_b_load;
    logic               w_a_hit;
    logic               w_b_hit;
    logic               w_stall;
    logic               w_issue;
    sb_entry_t          w_new;

    hazard_match #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .SEL_W    (c_SEL_W)
    ) u_match_a (
        .i_src           (rf_rn),
        .i_src_used      (rf_rn_used),
        .i_entries       (r_sb_q),
        .o_match_idx     (w_a_idx),
        .o_match_is_load (w_a_load)
    );

    hazard_match #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .SEL_W    (c_SEL_W)
    ) u_match_b (
        .i_src           (rf_rm),
        .i_src_used      (rf_rm_used),
        .i_entries       (r_sb_q),
        .o_match_idx     (w_b_idx),
        .o_match_is_load (w_b_load)
    );

    // Only the youngest producer matters: a younger ALU result shadows an
    // older load, because the matcher already returns the youngest hit.
    always_comb begin
        w_a_hit = (w_a_idx != '0) && w_a_load && (w_a_idx <= c_LOAD_LAT);
        w_b_hit = (w_b_idx != '0) && w_b_load && (w_b_idx <= c_LOAD_LAT);
        w_stall = rf_valid && !flush && (w_a_hit || w_b_hit);
        w_issue = rf_valid && !w_stall && !flush;
    end

    always_comb begin
        w_new.valid     = 1'b1;
        w_new.rd        = c_RD_MAX_W'(rf_rd);
        w_new.reg_write = rf_reg_write;
        w_new.is_load   = rf_is_load;

        w_sb_d    = r_sb_q;
        w_sb_d[0] = w_issue ? w_new : '0;
        for (int k = 1; k < DEPTH; k++) begin
            w_sb_d[k] = r_sb_q[k-1];
        end

        w_stall_cnt_d = r_stall_cnt_q;
        if (w_stall && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_q        <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_sb_q        <= w_sb_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall     = w_stall;
    assign fwd_sel_a = rf_valid ? w_a_idx : '0;
    assign fwd_sel_b = rf_valid ? w_b_idx : '0;
    assign stall_cnt = r_stall_cnt_q;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard (CNT_W = 4).
//                Per-cycle vector table plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       rf_valid;
    logic [4:0] rf_rn;
    logic [4:0] rf_rm;
    logic       rf_rn_used;
    logic       rf_rm_used;
    logic [4:0] rf_rd;
    logic       rf_reg_write;
    logic       rf_is_load;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [3:0] stall_cnt;

    int n_checks;
    int n_fail;

    hazard_scoreboard #(
        .ADDR_W   (5),
        .DEPTH    (3),
        .LOAD_LAT (1),
        .ZERO_REG (31),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rf_valid     (rf_valid),
        .rf_rn        (rf_rn),
        .rf_rm        (rf_rm),
        .rf_rn_used   (rf_rn_used),
        .rf_rm_used   (rf_rm_used),
        .rf_rd        (rf_rd),
        .rf_reg_write (rf_reg_write),
        .rf_is_load   (rf_is_load),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rn;
        logic       rnu;
        logic [4:0] rm;
        logic       rmu;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_sa;
        logic [1:0] e_sb;
        logic [3:0] e_cnt;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(input logic v, input int rn, input logic rnu,
                                input int rm, input logic rmu, input int rd,
                                input logic rw, input logic ld, input logic fl,
                                input logic es, input int esa, input int esb,
                                input int ecnt);
        vec_t t;
        t.v = v;  t.rn = 5'(rn); t.rnu = rnu; t.rm = 5'(rm); t.rmu = rmu;
        t.rd = 5'(rd); t.rw = rw; t.ld = ld; t.fl = fl;
        t.e_stall = es; t.e_sa = 2'(esa); t.e_sb = 2'(esb); t.e_cnt = 4'(ecnt);
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rn, input logic rnu,
                         input int rm, input logic rmu, input int rd,
                         input logic rw, input logic ld, input logic fl,
                         input logic rs);
        rf_valid = v;  rf_rn = 5'(rn); rf_rn_used = rnu;
        rf_rm = 5'(rm); rf_rm_used = rmu; rf_rd = 5'(rd);
        rf_reg_write = rw; rf_is_load = ld; flush = fl; reset = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Dependency chain, forwarding distances, load-use, XZR, flush.
        vecs[0]  = mk(0,  0,0,  0,0,  0,0,0, 0,  0,0,0,0);
        vecs[1]  = mk(1,  2,1,  3,1,  1,1,0, 0,  0,0,0,0);
        vecs[2]  = mk(1,  1,1,  5,1,  4,1,0, 0,  0,1,0,0);
        vecs[3]  = mk(1,  4,1,  1,1,  6,1,0, 0,  0,1,2,0);
        vecs[4]  = mk(1,  1,1,  6,1,  7,0,0, 0,  0,3,1,0);
        vecs[5]  = mk(1,  7,1,  4,1,  7,0,0, 0,  0,0,3,0);
        vecs[6]  = mk(1,  9,1,  9,0,  2,1,1, 0,  0,0,0,0);
        vecs[7]  = mk(1,  8,1,  2,1, 10,1,0, 0,  1,0,1,0);
        vecs[8]  = mk(1,  8,1,  2,1, 10,1,0, 0,  0,0,2,1);
        vecs[9]  = mk(1,  0,0,  0,0,  3,1,0, 0,  0,0,0,1);
        vecs[10] = mk(1,  3,1,  0,0, 11,1,0, 0,  0,1,0,1);
        vecs[11] = mk(1, 11,1, 10,1,  3,1,0, 0,  0,1,3,1);
        vecs[12] = mk(1,  3,1,  3,1, 31,1,0, 0,  0,1,1,1);
        vecs[13] = mk(1, 31,1, 31,1, 12,1,0, 0,  0,0,0,1);
        vecs[14] = mk(1, 12,0,  3,1,  0,0,0, 0,  0,0,3,1);
        vecs[15] = mk(0, 12,1, 12,1,  0,0,0, 0,  0,0,0,1);
        vecs[16] = mk(1,  0,0,  0,0, 13,1,1, 0,  0,0,0,1);
        vecs[17] = mk(1,  0,0,  0,0, 13,1,0, 0,  0,0,0,1);
        vecs[18] = mk(1, 13,1,  0,0, 14,1,1, 0,  0,1,0,1);
        vecs[19] = mk(1, 14,1,  0,0, 15,1,0, 1,  0,1,0,1);
        vecs[20] = mk(1, 14,1, 15,1,  0,0,0, 0,  0,2,0,1);

        drive(0, 0,0, 0,0, 0,0,0, 0, 1);
        tick();
        tick();

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].v, int'(vecs[i].rn), vecs[i].rnu, int'(vecs[i].rm),
                  vecs[i].rmu, int'(vecs[i].rd), vecs[i].rw, vecs[i].ld,
                  vecs[i].fl, 1'b0);
            check($sformatf("vec%0d stall", i), int'(stall), int'(vecs[i].e_stall));
            check($sformatf("vec%0d fwd_sel_a", i), int'(fwd_sel_a), int'(vecs[i].e_sa));
            check($sformatf("vec%0d fwd_sel_b", i), int'(fwd_sel_b), int'(vecs[i].e_sb));
            check($sformatf("vec%0d stall_cnt", i), int'(stall_cnt), int'(vecs[i].e_cnt));
            tick();
        end

        // Twenty load-use stalls: counter climbs from 1 and saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0,0, 0,0, 20,1,1, 0, 0);
            check($sformatf("sat%0d issue stall", i), int'(stall), 0);
            tick();
            drive(1, 20,1, 0,0, 0,0,0, 0, 0);
            check($sformatf("sat%0d stall", i), int'(stall), 1);
            check($sformatf("sat%0d cnt_in_stall", i), int'(stall_cnt),
                  (1 + i > 15) ? 15 : 1 + i);
            tick();
            check($sformatf("sat%0d release", i), int'(stall), 0);
            check($sformatf("sat%0d fwd_a", i), int'(fwd_sel_a), 2);
            check($sformatf("sat%0d cnt_after", i), int'(stall_cnt),
                  (2 + i > 15) ? 15 : 2 + i);
            tick();
        end

        // Invalid RF instruction never stalls even with a fresh load match.
        drive(1, 0,0, 0,0, 21,1,1, 0, 0);
        tick();
        drive(0, 21,1, 21,1, 0,0,0, 0, 0);
        check("novalid stall", int'(stall), 0);
        check("novalid fwd_a", int'(fwd_sel_a), 0);
        check("novalid cnt", int'(stall_cnt), 15);
        tick();

        // Reset in the middle of a load-use stall.
        drive(1, 0,0, 0,0, 22,1,1, 0, 0);
        tick();
        drive(1, 22,1, 22,1, 0,0,0, 0, 1);
        check("rst_mid stall_before", int'(stall), 1);
        tick();
        drive(1, 22,1, 22,1, 0,0,0, 0, 0);
        check("rst_mid stall_after", int'(stall), 0);
        check("rst_mid fwd_a", int'(fwd_sel_a), 0);
        check("rst_mid fwd_b", int'(fwd_sel_b), 0);
        check("rst_mid cnt", int'(stall_cnt), 0);
        tick();

        // Reset overrides a simultaneous issue.
        drive(1, 0,0, 0,0, 24,1,0, 0, 1);
        tick();
        drive(1, 24,1, 24,1, 0,0,0, 0, 0);
        check("rst_issue fwd_a", int'(fwd_sel_a), 0);
        check("rst_issue fwd_b", int'(fwd_sel_b), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
